pixel_readout_scheduler: RTL

//  Global-shutter frame sequencer for an N-row pixel array sharing one ramp ADC and one read bus.

---
 rtl/pixel_sched_pkg.sv | 23 ++
 rtl/pixel_readout_scheduler_if.sv | 15 +
 rtl/pixel_phase_timer.sv | 35 +++
 rtl/pixel_readout_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pixel_sched_pkg.sv
// Shared types and helpers for the pixel readout scheduler.
package pixel_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StErase,
    StExpose,
    StConvert,
    StRead,
    StHold,
    StDone
  } state_t;

  // $clog2 that never returns 0, so a single-row array still gets a 1-bit index.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pixel_readout_scheduler_if.sv
// Valid/ready stream carrying one captured row code and its row index.
interface pixel_readout_scheduler_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ROW_W  = 1
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [ROW_W-1:0]  row;

  modport master (output valid, output data, output row, input ready);
  modport slave  (input valid, input data, input row, output ready);

endinterface

// File: rtl/pixel_phase_timer.sv
// Countdown timer shared by every phase: load a value, count to zero, hold at zero.
module pixel_phase_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority; otherwise count down and saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pixel_readout_scheduler.sv
// Global-shutter frame sequencer: ERASE -> EXPOSE -> CONVERT -> per-row READ/HOLD -> DONE.
// Optional feature macro: PIXEL_SCHED_TESTPATTERN_EN adds test_mode, which replaces the
// captured pixel code with {row, frame_cnt}.
module pixel_readout_scheduler
  import pixel_sched_pkg::*;
#(
  parameter int unsigned N_ROWS    = 2,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned C_ERASE   = 5,
  parameter int unsigned C_EXPOSE  = 255,
  parameter int unsigned C_CONVERT = 255,
  parameter int unsigned C_READ    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
`ifdef PIXEL_SCHED_TESTPATTERN_EN
  input  logic              test_mode,
`endif
  output logic              erase,
  output logic              expose,
  output logic              convert,
  output logic              read,
  output logic [N_ROWS-1:0] row_sel,
  input  logic [DATA_W-1:0] pix_data,
  pixel_readout_scheduler_if.master out,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned ROW_W = clog2_min1(N_ROWS);
  localparam int unsigned MaxC  = max_u(max_u(C_ERASE, C_EXPOSE), max_u(C_CONVERT, C_READ));
  localparam int unsigned TW    = $clog2(MaxC + 1);

  localparam logic [TW-1:0]    LdErase   = TW'(C_ERASE - 1);
  localparam logic [TW-1:0]    LdExpose  = TW'(C_EXPOSE - 1);
  localparam logic [TW-1:0]    LdConvert = TW'(C_CONVERT - 1);
  localparam logic [TW-1:0]    LdRead    = TW'(C_READ - 1);
  localparam logic [ROW_W-1:0] LastRow   = ROW_W'(N_ROWS - 1);

  // Reset: assertion reaches every flop at once, release is aligned to clk.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Two-flop reset release synchroniser.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              tmr_load;
  logic [TW-1:0]     tmr_value;
  logic              tmr_zero;
  logic              capture;
  logic [DATA_W-1:0] cap_data;

  logic              erase_q, expose_q, convert_q, read_q, valid_q, busy_q, done_q;
  logic [N_ROWS-1:0] row_sel_q;
  logic [DATA_W-1:0] data_q;
  logic [ROW_W-1:0]  out_row_q;

  pixel_phase_timer #(
    .W (TW)
  ) u_timer (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .zero_o  (tmr_zero)
  );

`ifdef PIXEL_SCHED_TESTPATTERN_EN
  logic [3:0]       frame_cnt_q;
  logic [ROW_W+3:0] tp_code;

  // Frame counter advances once per completed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (state_q == StDone) begin
      frame_cnt_q <= frame_cnt_q + 4'd1;
    end
  end

  assign tp_code  = {row_q, frame_cnt_q};
  assign cap_data = test_mode ? DATA_W'(tp_code) : pix_data;
`else
  assign cap_data = pix_data;
`endif

  // Next-state logic; the timer is reloaded on every transition into a timed phase.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    capture   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StErase;
          tmr_load  = 1'b1;
          tmr_value = LdErase;
        end
      end
      StErase: begin
        if (tmr_zero) begin
          state_d   = StExpose;
          tmr_load  = 1'b1;
          tmr_value = LdExpose;
        end
      end
      StExpose: begin
        if (tmr_zero) begin
          state_d   = StConvert;
          tmr_load  = 1'b1;
          tmr_value = LdConvert;
        end
      end
      StConvert: begin
        if (tmr_zero) begin
          state_d   = StRead;
          tmr_load  = 1'b1;
          tmr_value = LdRead;
        end
      end
      StRead: begin
        if (tmr_zero) begin
          state_d = StHold;
          capture = 1'b1;
        end
      end
      StHold: begin
        if (out.ready) begin
          if (row_q == LastRow) begin
            state_d = StDone;
          end else begin
            row_d     = row_q + ROW_W'(1);
            state_d   = StRead;
            tmr_load  = 1'b1;
            tmr_value = LdRead;
          end
        end
      end
      StDone: begin
        row_d = '0;
        if (continuous) begin
          state_d   = StErase;
          tmr_load  = 1'b1;
          tmr_value = LdErase;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State plus registered outputs, all decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      row_q     <= '0;
      erase_q   <= 1'b0;
      expose_q  <= 1'b0;
      convert_q <= 1'b0;
      read_q    <= 1'b0;
      row_sel_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
      out_row_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      erase_q   <= (state_d == StErase);
      expose_q  <= (state_d == StExpose);
      convert_q <= (state_d == StConvert);
      read_q    <= (state_d == StRead);
      row_sel_q <= (state_d == StRead) ? (N_ROWS'(1) << row_d) : '0;
      valid_q   <= (state_d == StHold);
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_d == StDone);
      if (capture) begin
        data_q    <= cap_data;
        out_row_q <= row_q;
      end
    end
  end

  assign erase      = erase_q;
  assign expose     = expose_q;
  assign convert    = convert_q;
  assign read       = read_q;
  assign row_sel    = row_sel_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign out.valid  = valid_q;
  assign out.data   = data_q;
  assign out.row    = out_row_q;

endmodule
